// File: rtl/line_mem_responder_if.sv
// ---------------------------------------------------------------------------
// line_mem_responder_if
// Word-serial memory request/response bundle between the cache-line adapter
// (master) and the line memory responder (slave).
//   addr      : byte address of the current beat      (master -> slave)
//   mem_re    : read request, held for the whole burst (master -> slave)
//   mem_we    : write request, held for the whole burst(master -> slave)
//   m_data_i  : write data                             (master -> slave)
//   m_data_o  : registered read data                   (slave -> master)
//   m_o_valid : one-cycle beat acknowledge             (slave -> master)
//   mem_err   : sticky protocol error flag             (slave -> master)
// ---------------------------------------------------------------------------
interface line_mem_responder_if;
    logic [31:0] addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] m_data_i;
    logic [31:0] m_data_o;
    logic        m_o_valid;
    logic        mem_err;

    modport master (
        output addr, mem_re, mem_we, m_data_i,
        input  m_data_o, m_o_valid, mem_err
    );

    modport slave (
        input  addr, mem_re, mem_we, m_data_i,
        output m_data_o, m_o_valid, mem_err
    );
endinterface

// File: rtl/line_mem_responder.sv
// ---------------------------------------------------------------------------
// line_mem_responder
// Word-serial memory responder serving the cache-line adapter burst protocol.
// Each read or write beat is acknowledged with a one-cycle m_o_valid pulse;
// reads return data LAT wait cycles after the request is sampled, writes are
// committed on the sampling edge. Exactly WORDS beats are served per burst,
// after which trailing request cycles are absorbed until the bus is released.
// Ports:
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : line_mem_responder_if.slave (addr, mem_re, mem_we, m_data_i in;
//           m_data_o, m_o_valid, mem_err out, all outputs registered)
// ---------------------------------------------------------------------------
module line_mem_responder #(
    parameter int WORDS = 8,
    parameter int LAT   = 2,
    parameter int DEPTH = 1024
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    line_mem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(LAT + 1);
    localparam int BW = $clog2(WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RWAIT = 3'd1,
        RRESP = 3'd2,
        WACK  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_r;
    logic [BW-1:0]   beat_r;
    logic [LW-1:0]   lcnt_r;
    logic [31:0]     mem_r [DEPTH];

    logic [AW-1:0]   widx_s;
    logic            wr_en_s;
    logic            err_hit_s;
    logic            unused_s;

    // Upper address bits are deliberately dropped so accesses wrap modulo DEPTH.
    assign widx_s   = bus.addr[AW+1:2];
    assign unused_s = ^{bus.addr[31:AW+2]};

    // Decode the array write strobe and the protocol-error condition for IDLE.
    always_comb begin
        wr_en_s   = 1'b0;
        err_hit_s = 1'b0;
        if (state_r == IDLE) begin
            // A write is only committed when it is not shadowed by a read, and
            // never while reset is held so an in-flight beat cannot slip in.
            wr_en_s   = RST_N & bus.mem_we & ~bus.mem_re;
            err_hit_s = (bus.mem_re & bus.mem_we) |
                        ((bus.mem_re | bus.mem_we) & (bus.addr[1:0] != 2'b00));
        end else begin
            wr_en_s   = 1'b0;
            err_hit_s = 1'b0;
        end
    end

    // Word array: not reset, contents survive a reset.
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            mem_r[widx_s] <= bus.m_data_i;
        end
    end

    // Burst FSM with beat/latency counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r       <= IDLE;
            beat_r        <= {BW{1'b0}};
            lcnt_r        <= {LW{1'b0}};
            bus.m_o_valid <= 1'b0;
            bus.m_data_o  <= 32'h0000_0000;
            bus.mem_err   <= 1'b0;
        end else begin
            bus.m_o_valid <= 1'b0;
            if (err_hit_s) begin
                bus.mem_err <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (bus.mem_re) begin
                        state_r <= RWAIT;
                        lcnt_r  <= LW'(LAT - 1);
                    end else if (bus.mem_we) begin
                        // The write itself lands in the array on this edge.
                        state_r       <= WACK;
                        bus.m_o_valid <= 1'b1;
                    end else begin
                        beat_r <= {BW{1'b0}};
                    end
                end
                RWAIT: begin
                    if (!bus.mem_re) begin
                        state_r <= IDLE;
                        beat_r  <= {BW{1'b0}};
                    end else if (lcnt_r != {LW{1'b0}}) begin
                        lcnt_r <= lcnt_r - LW'(1);
                    end else begin
                        // Address is taken from this final wait cycle.
                        bus.m_data_o  <= mem_r[widx_s];
                        bus.m_o_valid <= 1'b1;
                        state_r       <= RRESP;
                    end
                end
                RRESP, WACK: begin
                    if (beat_r == BW'(WORDS - 1)) begin
                        beat_r  <= {BW{1'b0}};
                        state_r <= DONE;
                    end else begin
                        beat_r  <= beat_r + BW'(1);
                        state_r <= IDLE;
                    end
                end
                DONE: begin
                    if (!bus.mem_re && !bus.mem_we) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_line_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_line_mem_responder
// Directed bench for line_mem_responder (WORDS=8, LAT=2, DEPTH=1024).
// Bursts are driven from address/data tables; each cycle the acknowledge is
// compared with the hand-derived beat schedule and read data with the table
// of expected words.
// ---------------------------------------------------------------------------
module tb_line_mem_responder;
    localparam int WORDS = 8;
    localparam int LAT   = 2;

    logic CLK;
    logic RST_N;
    line_mem_responder_if bus ();

    line_mem_responder #(.WORDS(WORDS), .LAT(LAT), .DEPTH(1024)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] addr_tab [WORDS];
    logic [31:0] data_tab [WORDS];
    logic [31:0] exp_tab  [WORDS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.m_o_valid}, 32'd0);
        chk({tag, "_data"},  bus.m_data_o, 32'd0);
        chk({tag, "_err"},   {31'd0, bus.mem_err}, 32'd0);
    endtask

    // Drive one burst from the tables. nexp = beats expected; at stop_cyc the
    // requests are dropped (abort) or, with stop_rst, reset is asserted.
    task automatic burst(input bit rd, input bit wr, input int nexp,
                         input int stop_cyc, input bit stop_rst, input logic exp_err);
        int  first;
        int  period;
        int  beat;
        int  drop_cyc;
        bit  stopped;
        bit  exp_v;
        first    = rd ? (LAT + 1) : 1;
        period   = rd ? (LAT + 2) : 2;
        beat     = 0;
        drop_cyc = -1;
        stopped  = 1'b0;
        bus.addr     = addr_tab[0];
        bus.m_data_i = data_tab[0];
        bus.mem_re   = rd;
        bus.mem_we   = wr;
        for (int cyc = 1; cyc < 200; cyc++) begin
            @(posedge CLK);
            #1;
            exp_v = !stopped && (beat < nexp) && (cyc == first + beat * period);
            chk("valid", {31'd0, bus.m_o_valid}, {31'd0, exp_v});
            if (exp_v) begin
                if (rd) chk("rdata", bus.m_data_o, exp_tab[beat]);
                beat++;
                if (beat < WORDS) begin
                    bus.addr     = addr_tab[beat];
                    bus.m_data_i = data_tab[beat];
                end else begin
                    // Trailing cycle keeps the last address with junk data.
                    bus.m_data_i = 32'hFFFF_FFFF;
                    drop_cyc     = cyc + 2;
                end
            end
            if (cyc == stop_cyc) begin
                stopped    = 1'b1;
                bus.mem_re = 1'b0;
                bus.mem_we = 1'b0;
                drop_cyc   = cyc;
                if (stop_rst) begin
                    RST_N = 1'b0;
                    #1;
                    chk_outs_zero("rst_mid");
                end
            end
            if (cyc == drop_cyc) begin
                bus.mem_re = 1'b0;
                bus.mem_we = 1'b0;
            end
            if (drop_cyc >= 0 && cyc >= drop_cyc + 4) break;
        end
        chk("beats", beat, nexp);
        chk("err", {31'd0, bus.mem_err}, {31'd0, exp_err});
    endtask

    task automatic pulse_reset();
        RST_N = 1'b0;
        #1;
        chk_outs_zero("rst");
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N        = 1'b0;
        bus.addr     = 32'd0;
        bus.mem_re   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.m_data_i = 32'd0;

        // Reset held 3 cycles, then idle for 20 cycles.
        repeat (3) @(posedge CLK);
        #1;
        chk_outs_zero("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            chk_outs_zero("idle");
        end

        // Write burst, descending 0x5C..0x40, data 0x11..0x88.
        for (int k = 0; k < WORDS; k++) begin
            addr_tab[k] = 32'h0000_005C - 32'(4 * k);
            data_tab[k] = 32'h0000_0011 * 32'(k + 1);
        end
        burst(1'b0, 1'b1, 8, -1, 1'b0, 1'b0);

        // Read back the same addresses; word 16 must still hold 0x88.
        for (int k = 0; k < WORDS; k++) begin
            exp_tab[k]  = data_tab[k];
            data_tab[k] = 32'hDEAD_0000 + 32'(k);
        end
        burst(1'b1, 1'b0, 8, -1, 1'b0, 1'b0);

        // Abort in beat 1 wait, then a full burst from beat 0.
        burst(1'b1, 1'b0, 1, 5, 1'b0, 1'b0);
        burst(1'b1, 1'b0, 8, -1, 1'b0, 1'b0);

        // Preload words 32..39, then a misaligned read sets the error.
        for (int k = 0; k < WORDS; k++) begin
            addr_tab[k] = 32'h0000_0080 + 32'(4 * k);
            data_tab[k] = 32'h0000_00A0 + 32'(k);
            exp_tab[k]  = data_tab[k];
        end
        burst(1'b0, 1'b1, 8, -1, 1'b0, 1'b0);
        for (int k = 0; k < WORDS; k++) addr_tab[k] = 32'h0000_0083 + 32'(4 * k);
        burst(1'b1, 1'b0, 8, -1, 1'b0, 1'b1);
        pulse_reset();

        // Read and write together: read wins, no write, error sticks.
        for (int k = 0; k < WORDS; k++) begin
            addr_tab[k] = 32'h0000_0080 + 32'(4 * k);
            data_tab[k] = 32'h5555_0000 + 32'(k);
        end
        burst(1'b1, 1'b1, 8, -1, 1'b0, 1'b1);
        // Wrapped address (above DEPTH) reads the same words; error still set.
        for (int k = 0; k < WORDS; k++) addr_tab[k] = 32'h0000_1080 + 32'(4 * k);
        burst(1'b1, 1'b0, 8, -1, 1'b0, 1'b1);
        pulse_reset();

        // Preload words 48..55, then reset in cycle 6 of a new write burst.
        for (int k = 0; k < WORDS; k++) begin
            addr_tab[k] = 32'h0000_00C0 + 32'(4 * k);
            data_tab[k] = 32'h0000_0200 + 32'(k);
        end
        burst(1'b0, 1'b1, 8, -1, 1'b0, 1'b0);
        for (int k = 0; k < WORDS; k++) data_tab[k] = 32'h0000_0100 + 32'(k);
        burst(1'b0, 1'b1, 3, 6, 1'b1, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < WORDS; k++) begin
            exp_tab[k] = (k < 3) ? (32'h0000_0100 + 32'(k)) : (32'h0000_0200 + 32'(k));
        end
        burst(1'b1, 1'b0, 8, -1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
